// File: rtl/rv_mem_responder.sv
// rv_mem_responder
// ----------------
// Memory-side responder for the rv_mem command/result protocol. Commands are
// accepted from a cache-style requester, serviced from a word-addressed
// array, and answered in order after a fixed pipeline latency.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   command_valid  command present
//   command_ready  responder can accept a command (registered)
//   command_write  1 = write, 0 = read
//   command_addr   word address
//   command_data   write data (ignored for reads)
//   result_valid   result present
//   result_ready   consumer accepts the result
//   result_write   echo of command_write
//   result_addr    echo of command_addr
//   result_data    read data, or written data for propagated writes
//
// Structure: a LATENCY-deep valid/payload shift register feeds a small result
// queue. When the queue is empty the last pipeline stage is presented on the
// result port directly, so the first result shows up LATENCY cycles after
// acceptance. A credit counter bounds the number of result-producing commands
// in flight plus queued to the queue depth, so the non-stallable pipeline can
// never overflow the queue.
module rv_mem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int LATENCY         = 2,
    parameter int WRITE_PROPAGATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  command_valid,
    output logic                  command_ready,
    input  logic                  command_write,
    input  logic [ADDR_WIDTH-1:0] command_addr,
    input  logic [DATA_WIDTH-1:0] command_data,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  result_write,
    output logic [ADDR_WIDTH-1:0] result_addr,
    output logic [DATA_WIDTH-1:0] result_data
);

    localparam int DEPTH    = LATENCY + 1;
    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int LAST     = LATENCY - 1;
    localparam int MEM_WORDS = 2 ** ADDR_WIDTH;

    // Backing array: not reset, contents survive rst.
    logic [DATA_WIDTH-1:0] r_mem [0:MEM_WORDS-1];

    // Pipeline stages.
    logic                  r_stg_valid [0:LATENCY-1];
    logic                  r_stg_write [0:LATENCY-1];
    logic [ADDR_WIDTH-1:0] r_stg_addr  [0:LATENCY-1];
    logic [DATA_WIDTH-1:0] r_stg_data  [0:LATENCY-1];

    // Result queue (circular buffer, DEPTH entries).
    logic                  r_q_write [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_q_addr  [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_q_data  [0:DEPTH-1];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_q_count;

    logic [CW-1:0]         r_credit;
    logic [CW-1:0]         w_credit_next;
    logic                  r_cmd_ready;

    logic                  w_accept;
    logic                  w_produce;
    logic                  w_inc;
    logic                  w_q_empty;
    logic                  w_out_valid;
    logic                  w_out_write;
    logic [ADDR_WIDTH-1:0] w_out_addr;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic                  w_handshake;
    logic                  w_q_push;
    logic                  w_q_pop;

    genvar gi;

    assign w_accept  = command_valid && r_cmd_ready;
    assign w_produce = !command_write || (WRITE_PROPAGATE != 0);
    assign w_inc     = w_accept && w_produce;

    // ------------------------------------------------------------------
    // Array write and stage 0 (array read registered at the acceptance edge)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept && command_write) begin
            r_mem[command_addr] <= command_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stg_valid[0] <= 1'b0;
        end else begin
            r_stg_valid[0] <= w_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_stg_write[0] <= command_write;
            r_stg_addr[0]  <= command_addr;
            r_stg_data[0]  <= command_write ? command_data : r_mem[command_addr];
        end
    end

    // Remaining stages just shift; the pipeline never stalls.
    for (gi = 1; gi < LATENCY; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_stg_valid[gi] <= 1'b0;
            end else begin
                r_stg_valid[gi] <= r_stg_valid[gi-1];
            end
        end

        always_ff @(posedge clk) begin
            r_stg_write[gi] <= r_stg_write[gi-1];
            r_stg_addr[gi]  <= r_stg_addr[gi-1];
            r_stg_data[gi]  <= r_stg_data[gi-1];
        end
    end

    // ------------------------------------------------------------------
    // Result head: queue head if anything is queued, otherwise the last
    // stage bypasses straight to the port. A bypassed result that is not
    // taken drops into the (empty) queue, so the port value stays stable.
    // ------------------------------------------------------------------
    assign w_q_empty   = (r_q_count == '0);
    assign w_out_valid = !w_q_empty || r_stg_valid[LAST];
    assign w_out_write = w_q_empty ? r_stg_write[LAST] : r_q_write[r_rd_ptr];
    assign w_out_addr  = w_q_empty ? r_stg_addr[LAST]  : r_q_addr[r_rd_ptr];
    assign w_out_data  = w_q_empty ? r_stg_data[LAST]  : r_q_data[r_rd_ptr];

    assign w_handshake = w_out_valid && result_ready;
    assign w_q_push    = r_stg_valid[LAST] && !(w_q_empty && result_ready);
    assign w_q_pop     = w_handshake && !w_q_empty;

    // Payload is forced to zero whenever no result is presented; this also
    // gives zero outputs during reset without resetting the data storage.
    assign result_valid = w_out_valid;
    assign result_write = w_out_valid & w_out_write;
    assign result_addr  = {ADDR_WIDTH{w_out_valid}} & w_out_addr;
    assign result_data  = {DATA_WIDTH{w_out_valid}} & w_out_data;

    always_ff @(posedge clk) begin
        if (w_q_push) begin
            r_q_write[r_wr_ptr] <= r_stg_write[LAST];
            r_q_addr[r_wr_ptr]  <= r_stg_addr[LAST];
            r_q_data[r_wr_ptr]  <= r_stg_data[LAST];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_q_count <= '0;
        end else begin
            if (w_q_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_q_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_q_push, w_q_pop})
                2'b10:   r_q_count <= r_q_count + CW'(1);
                2'b01:   r_q_count <= r_q_count - CW'(1);
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Credit counter: result-producing commands in flight plus queued.
    // command_ready is registered from the next count, so it has no path
    // from command_valid and rises on the first edge after reset release.
    // ------------------------------------------------------------------
    always_comb begin
        w_credit_next = r_credit;
        case ({w_inc, w_handshake})
            2'b10:   w_credit_next = r_credit + CW'(1);
            2'b01:   w_credit_next = r_credit - CW'(1);
            default: w_credit_next = r_credit;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit    <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_credit    <= w_credit_next;
            r_cmd_ready <= (w_credit_next < CW'(DEPTH));
        end
    end

    assign command_ready = r_cmd_ready;

    // Simulation checks.
    always @(posedge clk) begin
        if (rst) begin
            assert (LATENCY >= 1 && LATENCY <= 4)
                else $fatal(1, "rv_mem_responder: LATENCY must be 1..4");
            assert (!(w_q_push && (r_q_count == CW'(DEPTH))))
                else $error("rv_mem_responder: result queue push when full");
            assert (!(w_q_pop && w_q_empty))
                else $error("rv_mem_responder: result queue pop when empty");
        end
    end

endmodule

// File: tb/tb_rv_mem_responder.sv
// Bench for rv_mem_responder. Two instances share one command/result_ready
// stimulus: dut0 (LATENCY=2, writes silent) and dut1 (LATENCY=3, writes
// propagate). Each has a reference model: an array plus a queue of expected
// results in command order; outstanding results bound command_ready.
module tb_rv_mem_responder;

    typedef struct packed {
        logic        w;
        logic [9:0]  a;
        logic [31:0] d;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_valid;
    logic        c_write;
    logic [9:0]  c_addr;
    logic [31:0] c_data;
    logic        r_ready;

    logic        cr [2];
    logic        rv [2];
    logic        rw [2];
    logic [9:0]  ra [2];
    logic [31:0] rd [2];

    int errors = 0;
    int checks = 0;

    res_t        q0[$];
    res_t        q1[$];
    logic [31:0] mem [2][1024];
    int          nacc [2];
    int          nres [2];
    logic        stall_prev [2];
    res_t        prev_p [2];
    bit          running = 1'b0;
    int          cyc = 0;
    logic [31:0] got0[$];
    int          got0_cyc[$];

    always #5 clk = ~clk;

    rv_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(2), .WRITE_PROPAGATE(0)) dut0 (
        .clk(clk), .rst(rst),
        .command_valid(c_valid), .command_ready(cr[0]), .command_write(c_write),
        .command_addr(c_addr), .command_data(c_data),
        .result_valid(rv[0]), .result_ready(r_ready), .result_write(rw[0]),
        .result_addr(ra[0]), .result_data(rd[0])
    );

    rv_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(3), .WRITE_PROPAGATE(1)) dut1 (
        .clk(clk), .rst(rst),
        .command_valid(c_valid), .command_ready(cr[1]), .command_write(c_write),
        .command_addr(c_addr), .command_data(c_data),
        .result_valid(rv[1]), .result_ready(r_ready), .result_write(rw[1]),
        .result_addr(ra[1]), .result_data(rd[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: evaluate the handshakes that the coming edge will perform
    // against the models, then advance to just after the edge.
    task automatic cycle();
        for (int i = 0; i < 2; i++) begin
            int   lat;
            bit   wp;
            int   qs;
            res_t o;
            res_t e;
            lat = (i == 0) ? 2 : 3;
            wp  = (i == 1);
            qs  = (i == 0) ? q0.size() : q1.size();
            o   = {rw[i], ra[i], rd[i]};
            if (!rst) begin
                chk($sformatf("reset_cmd_ready_dut%0d", i), 64'(cr[i]), 64'd0);
                chk($sformatf("reset_result_valid_dut%0d", i), 64'(rv[i]), 64'd0);
                chk($sformatf("reset_payload_dut%0d", i), 64'(o), 64'd0);
                if (i == 0) q0.delete(); else q1.delete();
                stall_prev[i] = 1'b0;
            end else begin
                if (running)
                    chk($sformatf("credit_ready_dut%0d", i), 64'(cr[i]), 64'(qs < lat + 1));
                if (stall_prev[i]) begin
                    chk($sformatf("stall_valid_dut%0d", i), 64'(rv[i]), 64'd1);
                    chk($sformatf("stall_payload_dut%0d", i), 64'(o), 64'(prev_p[i]));
                end
                if (rv[i]) begin
                    if (qs == 0) begin
                        chk($sformatf("spurious_result_dut%0d", i), 64'(rv[i]), 64'd0);
                    end else if (r_ready) begin
                        if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                        chk($sformatf("result_dut%0d", i), 64'(o), 64'(e));
                        $display("cyc %0d dut%0d result w=%0d a=0x%03h d=0x%08h", cyc, i, rw[i], ra[i], rd[i]);
                        nres[i]++;
                        if (i == 0) begin
                            got0.push_back(rd[0]);
                            got0_cyc.push_back(cyc);
                        end
                    end
                end
                stall_prev[i] = rv[i] && !r_ready;
                prev_p[i]     = o;
                if (c_valid && cr[i]) begin
                    e.w = c_write;
                    e.a = c_addr;
                    e.d = c_write ? c_data : mem[i][c_addr];
                    if (c_write) mem[i][c_addr] = c_data;
                    if (!c_write || wp) begin
                        if (i == 0) q0.push_back(e); else q1.push_back(e);
                    end
                    nacc[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        running = rst;
    endtask

    // Wait (bounded) for dut0 to present a read result, check it, consume it.
    task automatic wait_read0(input string tag, input logic [9:0] a, input logic [31:0] d);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (rv[0]) begin
                seen = 1'b1;
                chk(tag, 64'({rw[0], ra[0], rd[0]}), 64'({1'b0, a, d}));
            end else begin
                cycle();
            end
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0, n1, a0, kk;
        bit  seen;

        rst = 1'b0; c_valid = 1'b1; c_write = 1'b0; c_addr = '0; c_data = '0; r_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nacc[i] = 0; nres[i] = 0; stall_prev[i] = 1'b0; prev_p[i] = '0;
            for (int j = 0; j < 1024; j++) mem[i][j] = '0;
        end
        #1;

        // Reset held with command_valid high.
        repeat (5) cycle();
        rst = 1'b1; c_valid = 1'b0;
        chk("ready_low_before_edge", 64'(cr[0]), 64'd0);
        cycle();
        chk("ready_after_release", 64'(cr[0]), 64'd1);
        repeat (4) cycle();
        chk("idle_no_result", 64'(nres[0] + nres[1]), 64'd0);

        // Write then read, exact latency on dut0.
        c_valid = 1'b1; c_write = 1'b1; c_addr = 10'h010; c_data = 32'hDEADBEEF;
        cycle();
        c_write = 1'b0; n0 = nres[0];
        cycle();
        c_valid = 1'b0;
        chk("wr_rd_not_early", 64'(rv[0]), 64'd0);
        cycle();
        chk("wr_rd_valid", 64'(rv[0]), 64'd1);
        chk("wr_rd_payload", 64'({rw[0], ra[0], rd[0]}), 64'({1'b0, 10'h010, 32'hDEADBEEF}));
        repeat (5) cycle();
        chk("wr_rd_count", 64'(nres[0] - n0), 64'd1);

        // Streaming reads of pre-written addresses.
        for (int i = 0; i < 16; i++) begin
            c_valid = 1'b1; c_write = 1'b1; c_addr = 10'(i); c_data = 32'(i * 3);
            cycle();
        end
        c_valid = 1'b0;
        repeat (6) cycle();
        got0.delete(); got0_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            c_valid = 1'b1; c_write = 1'b0; c_addr = 10'(i);
            chk("stream_ready", 64'(cr[0]), 64'd1);
            cycle();
        end
        c_valid = 1'b0;
        repeat (6) cycle();
        chk("stream_count", 64'(got0.size()), 64'd16);
        for (int k = 0; k < got0.size(); k++) chk("stream_data", 64'(got0[k]), 64'(k * 3));
        if (got0.size() > 0)
            chk("stream_back_to_back", 64'(got0_cyc[got0.size() - 1] - got0_cyc[0]), 64'd15);

        // Backpressure until the queue fills.
        r_ready = 1'b0; a0 = nacc[0];
        for (int i = 0; i < 6; i++) begin
            c_valid = 1'b1; c_write = 1'b0; c_addr = 10'(i);
            cycle();
        end
        chk("bp_accepted", 64'(nacc[0] - a0), 64'd3);
        chk("bp_ready_low", 64'(cr[0]), 64'd0);
        got0.delete(); got0_cyc.delete();
        c_valid = 1'b0; r_ready = 1'b1;
        cycle();
        chk("bp_ready_after_pop", 64'(cr[0]), 64'd1);
        repeat (6) cycle();
        chk("bp_count", 64'(got0.size()), 64'd3);
        for (int k = 0; k < got0.size(); k++) chk("bp_data", 64'(got0[k]), 64'(k * 3));

        // Propagated write at the top address (dut1).
        c_valid = 1'b1; c_write = 1'b1; c_addr = 10'h3FF; c_data = 32'h12345678;
        chk("wp_ready", 64'(cr[1]), 64'd1);
        cycle();
        c_valid = 1'b0;
        seen = 1'b0; kk = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (rv[1]) begin
                seen = 1'b1;
                chk("wp_payload", 64'({rw[1], ra[1], rd[1]}), 64'({1'b1, 10'h3FF, 32'h12345678}));
            end else begin
                cycle();
                kk++;
            end
        end
        chk("wp_seen", 64'(seen), 64'd1);
        chk("wp_latency", 64'(kk), 64'd2);
        c_valid = 1'b1; c_write = 1'b0; c_addr = 10'h3FF;
        cycle();
        c_valid = 1'b0;
        wait_read0("max_addr_read", 10'h3FF, 32'h12345678);

        // Reset while two reads are in flight.
        repeat (4) cycle();
        r_ready = 1'b0; n0 = nres[0]; n1 = nres[1];
        c_valid = 1'b1; c_write = 1'b0; c_addr = 10'h3FF;
        cycle();
        c_addr = 10'h010;
        cycle();
        c_valid = 1'b0;
        chk("mid_no_result_dut1", 64'(rv[1]), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_reset_clears_dut0", 64'(rv[0]), 64'd0);
        repeat (2) cycle();
        rst = 1'b1; r_ready = 1'b1;
        repeat (6) cycle();
        chk("mid_discarded", 64'((nres[0] - n0) + (nres[1] - n1)), 64'd0);
        c_valid = 1'b1; c_write = 1'b0; c_addr = 10'h010;
        cycle();
        c_valid = 1'b0;
        wait_read0("post_reset_read", 10'h010, 32'hDEADBEEF);

        // Randomized traffic against the models.
        for (int i = 0; i < 400; i++) begin
            c_valid = ($urandom % 4) != 0;
            c_write = ($urandom % 3) == 0;
            c_addr  = (($urandom % 8) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
            c_data  = $urandom;
            r_ready = ($urandom % 4) != 0;
            cycle();
        end
        c_valid = 1'b0; r_ready = 1'b1;
        repeat (10) cycle();
        chk("drain_dut0", 64'(q0.size()), 64'd0);
        chk("drain_dut1", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
